// File: rtl/iic_fifo_pkg.sv
// Shared constants for the parameterised handshake FIFO: write-FSM states
// and the default parameter values used by iic_fifo_param.
package iic_fifo_pkg;

  localparam int DEF_DW           = 16;
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_AFULL_MARGIN = 2;
  localparam int DEF_AEMPTY_TH    = 1;
  localparam int DEF_ASYNC_IN     = 0;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } wr_state_e;

endpackage

// File: rtl/iic_sync2.sv
// Two-flop synchronizer that brings an asynchronous level into the clk_i domain.
module iic_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/iic_fifo_param.sv
// First-word fall-through ring-buffer FIFO with a four-phase write handshake,
// registered status flags, high-water mark, sticky underflow and loopback mode.
module iic_fifo_param
  import iic_fifo_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - DEF_AFULL_MARGIN,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  parameter int ASYNC_IN  = DEF_ASYNC_IN
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DW-1:0]            in_data_i,
  input  logic                     in_rdy_i,
  output logic                     in_ack_o,
  output logic [DW-1:0]            out_data_o,
  input  logic                     out_rd_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     afull_o,
  output logic                     aempty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [$clog2(DEPTH):0]   hwm_o,
  output logic                     udf_o,
  input  logic                     clr_i,
  input  logic                     tst_loop_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_TH);

  logic            rdy_s;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic [DW-1:0]   last_q, head, wr_data;
  logic            fsm_wr, loop_wr, rd_en, wr_en;
  wr_state_e       state_q, state_d;

  generate
    if (ASYNC_IN != 0) begin : g_sync
      iic_sync2 u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (in_rdy_i),
        .q_o   (rdy_s)
      );
    end else begin : g_nosync
      assign rdy_s = in_rdy_i;
    end
  endgenerate

  // The handshake write is gated by the registered full flag, so a pending
  // request lands on the edge after a pop clears full.
  always_comb begin
    state_d = state_q;
    fsm_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rdy_s && !full_o && !tst_loop_i) begin
          fsm_wr  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!rdy_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign in_ack_o   = (state_q == ACK);
  assign rd_en      = out_rd_i && !empty_o;
  assign loop_wr    = tst_loop_i && rd_en;
  assign wr_en      = fsm_wr || loop_wr;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign wr_data    = loop_wr ? head : in_data_i;
  assign out_data_o = empty_o ? last_q : head;

  assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_en);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd_en);
  assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Flags are derived from the next-state pointers so they always agree
  // with the pointer registers after the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_q   <= '0;
      level_o  <= '0;
      full_o   <= 1'b0;
      empty_o  <= 1'b1;
      afull_o  <= 1'b0;
      aempty_o <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      if (rd_en) last_q <= head;
      level_o  <= level_nxt;
      full_o   <= (level_nxt == FULL_LVL);
      empty_o  <= (level_nxt == '0);
      afull_o  <= (level_nxt >= AFULL_LVL);
      aempty_o <= (level_nxt <= AEMPTY_LVL);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hwm_o <= '0;
      udf_o <= 1'b0;
    end else begin
      if (clr_i)                  hwm_o <= level_nxt;
      else if (level_nxt > hwm_o) hwm_o <= level_nxt;
      if (out_rd_i && empty_o)    udf_o <= 1'b1;
      else if (clr_i)             udf_o <= 1'b0;
    end
  end

endmodule

// File: doc/iic_fifo_param.md
IIC_FIFO_PARAM -- requirements
Module: iic_fifo_param

Interface
REQ-001 Parameter DW, default 16: data width in bits, range 1..64.
REQ-002 Parameter DEPTH, default 8: entry count, power of two, range 2..256.
REQ-003 Parameter AFULL_TH, default DEPTH-2: almost-full threshold, range 1..DEPTH.
REQ-004 Parameter AEMPTY_TH, default 1: almost-empty threshold, range 0..DEPTH-1.
REQ-005 Parameter ASYNC_IN, default 0: 1 inserts a 2-FF synchronizer on in_rdy_i.
REQ-006 clk_i  in  1  single clock for all logic.
REQ-007 rst_i  in  1  reset; asynchronous and active-high.
REQ-008 in_data_i  in  DW  write datum, held stable by source while in_rdy_i is high.
REQ-009 in_rdy_i  in  1  source request, four-phase; may be asynchronous when ASYNC_IN=1.
REQ-010 in_ack_o  out  1  registered acknowledge; datum has been written.
REQ-011 out_data_o  out  DW  head datum (first-word fall-through).
REQ-012 out_rd_i  in  1  pop strobe, sampled each rising edge.
REQ-013 full_o, empty_o, afull_o, aempty_o  out  1 each  status flags.
REQ-014 level_o  out  clog2(DEPTH)+1  current fill count 0..DEPTH.
REQ-015 hwm_o  out  clog2(DEPTH)+1  high-water mark of level_o.
REQ-016 udf_o  out  1  sticky underflow flag.
REQ-017 clr_i  in  1  single-cycle clear of udf_o and hwm_o.
REQ-018 tst_loop_i  in  1  test mode: popped data recirculates into the FIFO.

Function
REQ-019 The FIFO SHALL be a ring buffer using write/read pointers of clog2(DEPTH)+1 bits; the pointers wrap modulo 2*DEPTH, and the extra MSB distinguishes full from empty.
REQ-020 The write handshake FSM SHALL have two states: IDLE (ack=0) and ACK (ack=1).
REQ-021 In IDLE with rdy_s=1, full_o=0 and tst_loop_i=0, the FSM SHALL write in_data_i at wr_ptr, increment wr_ptr and enter ACK at the same edge.
REQ-022 In ACK the FSM SHALL return to IDLE on the first edge with rdy_s=0; exactly one write SHALL occur per handshake.
REQ-023 rdy_s SHALL equal in_rdy_i when ASYNC_IN=0 and the 2-FF-synchronized in_rdy_i when ASYNC_IN=1; ack latency from the rdy rise SHALL be 1 or 3 edges respectively.
REQ-024 When full, the request SHALL wait in IDLE with ack low and no data lost; the write SHALL occur on the first edge at which full_o=0 is registered.
REQ-025 On an edge with out_rd_i=1 and empty_o=0, rd_ptr SHALL increment and the popped word SHALL be captured in last_q.
REQ-026 out_data_o SHALL equal mem[rd_ptr] when not empty and last_q when empty; a read on empty SHALL leave the pointers unchanged and set udf_o.
REQ-027 A write and a read on the same edge SHALL both take effect, leaving level_o unchanged.
REQ-028 With tst_loop_i=1, each successful pop SHALL rewrite the popped word at wr_ptr and advance wr_ptr, leaving level_o constant; in_ack_o SHALL never rise from IDLE.
REQ-029 A tst_loop_i change SHALL take effect at the next edge; an FSM already in ACK SHALL complete its handshake normally.
REQ-030 level_o, full_o (level=DEPTH), empty_o (level=0), afull_o (level>=AFULL_TH) and aempty_o (level<=AEMPTY_TH) SHALL be registered and consistent with the pointers after each edge.
REQ-031 hwm_o SHALL track max(level_o) since reset; clr_i SHALL clear udf_o and load hwm_o with the next-state level; a simultaneous underflow SHALL take priority over clr_i for udf_o.

Reset
REQ-032 Asserting rst_i SHALL immediately force: pointers 0, FSM IDLE, in_ack_o=0, last_q=0, level_o=0, hwm_o=0, udf_o=0, full_o=0, afull_o=0, empty_o=1, aempty_o=1, synchronizer flops 0.
REQ-033 The storage array SHALL NOT be reset; a reset mid-handshake SHALL abort the handshake, and the source SHALL restart it.

Structure
REQ-034 Package iic_fifo_pkg SHALL hold the FSM state constants (IDLE, ACK) and the default parameter values.
REQ-035 The synchronizer SHALL be a sub-module, iic_sync2, instantiated only when ASYNC_IN=1.

Verification
REQ-036 DEPTH=8, ASYNC_IN=0: write 0x0001..0x0008 -> full_o=1, level_o=8, hwm_o=8; a 9th request gets no ack until one pop, then acks 1 edge later.
REQ-037 Pop 8 words -> outputs 0x0001..0x0008 in order, empty_o=1, out_data_o=0x0008; a 9th pop sets udf_o=1 and leaves out_data_o=0x0008.
REQ-038 Run 20 write/pop pairs so the pointers wrap -> data order preserved, level_o never exceeds 1, afull/aempty thresholds toggle at the exact levels.
REQ-039 Level 4 with a same-edge write and pop -> level_o stays 4; with tst_loop_i=1 and 12 pops -> sequence 1,2,3,4 repeats and in_ack_o stays 0.
REQ-040 ASYNC_IN=1: rdy rise -> ack on the 3rd edge; assert rst_i while in ACK -> in_ack_o=0 at once, empty_o=1; clr_i -> udf_o=0 and hwm_o=level_o.
